// File: rtl/csa_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
// Shared definitions for the CSA PID table: frame geometry constants, the
// table entry layout and the write-side frame parser state encoding.
// ---------------------------------------------------------------------------
package csa_pkg;

  localparam int PID_W       = 13;
  localparam int ENTRY_BYTES = 4;
  localparam int HDR_BYTES   = 1;

  // One PID table entry as stored in a bank.
  typedef struct packed {
    logic             valid;
    logic             scr_en;
    logic [PID_W-1:0] pid;
    logic [7:0]       cw_idx;
  } pid_entry_t;

  // Frame parser states.
  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_HDR   = 2'd1,
    W_ENTRY = 2'd2,
    W_CHECK = 2'd3
  } wr_state_t;

endpackage

// File: rtl/csa_pid_cam.sv
// ---------------------------------------------------------------------------
// csa_pid_cam
// Two banks of PID entries plus a 2-stage lookup pipeline.
//   Writes (wr_en/wr_idx/wr_entry) and the bulk invalidate (clr_shadow)
//   always target the inactive bank, i.e. bank ~act_bank.
//   Lookup: stage 1 registers the match vector of the active bank, stage 2
//   priority-encodes it (lowest index wins) and registers the result.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   act_bank            bank currently answering lookups
//   clr_shadow          invalidate every entry of the inactive bank
//   wr_en, wr_idx,
//   wr_entry            single-entry write into the inactive bank
//   lk_req, lk_pid      lookup request (one per cycle, no backpressure)
//   lk_valid, lk_hit,
//   lk_scr_en, lk_cw_idx  lookup result, two cycles after lk_req
//
// Lookup protocol: lk_req is a pure strobe with no ready; every request
// produces exactly one lk_valid pulse two cycles later, in request order.
// ---------------------------------------------------------------------------
module csa_pid_cam
  import csa_pkg::*;
#(
  parameter int TABLE_DEPTH = 32,
  parameter int IDX_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             act_bank,
  input  logic             clr_shadow,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  pid_entry_t       wr_entry,
  input  logic             lk_req,
  input  logic [PID_W-1:0] lk_pid,
  output logic             lk_valid,
  output logic             lk_hit,
  output logic             lk_scr_en,
  output logic [7:0]       lk_cw_idx
);

  pid_entry_t mem [2][TABLE_DEPTH];

  logic [TABLE_DEPTH-1:0] cmp_d;
  logic [TABLE_DEPTH-1:0] cmp_q;
  logic                   stg_valid_q;
  logic                   stg_bank_q;
  logic                   enc_hit;
  logic [IDX_W-1:0]       enc_idx;
  logic                   enc_scr;
  logic [7:0]             enc_cw;

  // Bank storage. Only the inactive bank is ever modified.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < TABLE_DEPTH; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else begin
      if (clr_shadow) begin
        for (int i = 0; i < TABLE_DEPTH; i++) begin
          mem[~act_bank][i].valid <= 1'b0;
        end
      end
      if (wr_en) begin
        mem[~act_bank][wr_idx] <= wr_entry;
      end
    end
  end

  // Parallel compare against every valid entry of the active bank.
  always_comb begin
    cmp_d = '0;
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      cmp_d[i] = mem[act_bank][i].valid && (mem[act_bank][i].pid == lk_pid);
    end
  end

  // Stage 1. The bank is captured with the vector so stage 2 reads the
  // fields from the same bank even if act_bank toggles in between.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q       <= '0;
      stg_valid_q <= 1'b0;
      stg_bank_q  <= 1'b0;
    end else begin
      cmp_q       <= lk_req ? cmp_d : '0;
      stg_valid_q <= lk_req;
      stg_bank_q  <= act_bank;
    end
  end

  // Priority encode: scanning downwards leaves the lowest set index.
  always_comb begin
    enc_hit = 1'b0;
    enc_idx = '0;
    for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
      if (cmp_q[i]) begin
        enc_hit = 1'b1;
        enc_idx = IDX_W'(i);
      end
    end
    enc_scr = mem[stg_bank_q][enc_idx].scr_en;
    enc_cw  = mem[stg_bank_q][enc_idx].cw_idx;
  end

  // Stage 2: misses report all-zero fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_valid  <= 1'b0;
      lk_hit    <= 1'b0;
      lk_scr_en <= 1'b0;
      lk_cw_idx <= '0;
    end else begin
      lk_valid  <= stg_valid_q;
      lk_hit    <= enc_hit;
      lk_scr_en <= enc_hit & enc_scr;
      lk_cw_idx <= enc_hit ? enc_cw : 8'h00;
    end
  end

endmodule

// File: rtl/csa_pid_table.sv
// ---------------------------------------------------------------------------
// csa_pid_table
// Parses PID-configuration frames into the shadow bank of csa_pid_cam and
// commits them atomically by flipping the active-bank bit.
//   Frame: N, then N x {flags, pid_hi, pid_lo, cw_idx}.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pid_con_din[7:0]         config byte
//   pid_con_din_en           high for the whole frame, falling edge ends it
//   ts_pid[12:0],
//   ts_pid_valid             lookup request
//   lk_valid, lk_hit,
//   lk_scr_en, lk_cw_idx     lookup result, fixed 2-cycle latency
//   tbl_commit               1-cycle pulse when the new bank goes live
//   tbl_err                  1-cycle pulse when a frame is rejected
//   tbl_count[IDX_W:0]       entries in the active bank
//   dbg_state                current frame parser state
// ---------------------------------------------------------------------------
module csa_pid_table
  import csa_pkg::*;
#(
  parameter int TABLE_DEPTH = 32,
  parameter int IDX_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       pid_con_din,
  input  logic             pid_con_din_en,
  input  logic [PID_W-1:0] ts_pid,
  input  logic             ts_pid_valid,
  output logic             lk_valid,
  output logic             lk_hit,
  output logic             lk_scr_en,
  output logic [7:0]       lk_cw_idx,
  output logic             tbl_commit,
  output logic             tbl_err,
  output logic [IDX_W:0]   tbl_count,
  output wr_state_t        dbg_state
);

  localparam logic [7:0] DEPTH_N = 8'(TABLE_DEPTH);
  localparam logic [8:0] DEPTH_E = 9'(TABLE_DEPTH);

  wr_state_t      state_q, state_d;
  logic           din_en_q;
  logic [7:0]     n_q;
  logic [1:0]     byte_cnt_q;
  logic [8:0]     ent_cnt_q;   // completed entries, saturating
  logic           reject_q;
  logic           act_bank_q;
  logic [IDX_W:0] tbl_count_q;
  logic           tbl_commit_q;
  logic           tbl_err_q;
  logic           flags_q;
  logic [4:0]     pid_hi_q;
  logic [7:0]     pid_lo_q;

  logic           frame_start;
  logic           take_byte;
  logic           do_commit;
  logic           do_err;
  logic           len_ok;
  logic           wr_en;
  pid_entry_t     wr_entry;

  // Exactly 1 + 4*N bytes arrived: no partial entry and N whole entries.
  assign len_ok = (byte_cnt_q == 2'd0) && (ent_cnt_q == {1'b0, n_q});

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    take_byte   = 1'b0;
    do_commit   = 1'b0;
    do_err      = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (pid_con_din_en && !din_en_q) begin
          frame_start = 1'b1;
          state_d     = W_ENTRY;
        end
      end
      W_HDR: begin
        // The header is consumed directly from W_IDLE; this state is never
        // entered and simply falls back to idle.
        state_d = W_IDLE;
      end
      W_ENTRY: begin
        if (pid_con_din_en) begin
          take_byte = 1'b1;
        end else begin
          state_d = W_CHECK;
        end
      end
      W_CHECK: begin
        state_d = W_IDLE;
        if (len_ok && !reject_q) begin
          do_commit = 1'b1;
        end else begin
          do_err = 1'b1;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  assign wr_en    = take_byte && (byte_cnt_q == 2'd3) && !reject_q &&
                    (ent_cnt_q < DEPTH_E);
  assign wr_entry = '{valid:  1'b1,
                      scr_en: flags_q,
                      pid:    {pid_hi_q, pid_lo_q},
                      cw_idx: pid_con_din};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= W_IDLE;
      // Treat the enable as already high so the tail of a frame that was
      // cut by reset is not mistaken for a new frame start.
      din_en_q     <= 1'b1;
      n_q          <= '0;
      byte_cnt_q   <= '0;
      ent_cnt_q    <= '0;
      reject_q     <= 1'b0;
      act_bank_q   <= 1'b0;
      tbl_count_q  <= '0;
      tbl_commit_q <= 1'b0;
      tbl_err_q    <= 1'b0;
      flags_q      <= 1'b0;
      pid_hi_q     <= '0;
      pid_lo_q     <= '0;
    end else begin
      state_q      <= state_d;
      din_en_q     <= pid_con_din_en;
      tbl_commit_q <= do_commit;
      tbl_err_q    <= do_err;
      if (do_commit) begin
        act_bank_q  <= ~act_bank_q;
        tbl_count_q <= n_q[IDX_W:0];
      end
      if (frame_start) begin
        n_q        <= pid_con_din;
        byte_cnt_q <= '0;
        ent_cnt_q  <= '0;
        reject_q   <= (pid_con_din > DEPTH_N);
      end
      if (take_byte) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        if (ent_cnt_q >= DEPTH_E) begin
          reject_q <= 1'b1;
        end
        case (byte_cnt_q)
          2'd0:    flags_q  <= pid_con_din[0];
          2'd1:    pid_hi_q <= pid_con_din[4:0];
          2'd2:    pid_lo_q <= pid_con_din;
          default: begin
            if (ent_cnt_q != 9'h1FF) begin
              ent_cnt_q <= ent_cnt_q + 9'd1;
            end
          end
        endcase
      end
    end
  end

  csa_pid_cam #(
    .TABLE_DEPTH (TABLE_DEPTH),
    .IDX_W       (IDX_W)
  ) u_cam (
    .clk        (clk),
    .rst        (rst),
    .act_bank   (act_bank_q),
    .clr_shadow (frame_start),
    .wr_en      (wr_en),
    .wr_idx     (ent_cnt_q[IDX_W-1:0]),
    .wr_entry   (wr_entry),
    .lk_req     (ts_pid_valid),
    .lk_pid     (ts_pid),
    .lk_valid   (lk_valid),
    .lk_hit     (lk_hit),
    .lk_scr_en  (lk_scr_en),
    .lk_cw_idx  (lk_cw_idx)
  );

  assign tbl_commit = tbl_commit_q;
  assign tbl_err    = tbl_err_q;
  assign tbl_count  = tbl_count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_csa_pid_table.sv
// ---------------------------------------------------------------------------
// tb_csa_pid_table
// Drives configuration frames and random lookups into csa_pid_table. The
// reference keeps the live table as plain queues of (pid, scr, cw) and
// answers a lookup with a first-match linear search; a frame replaces the
// table only when it is well formed.
// ---------------------------------------------------------------------------
module tb_csa_pid_table;
  import csa_pkg::*;

  localparam int DEPTH = 32;
  localparam int IDX_W = 5;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pid_con_din;
  logic        pid_con_din_en;
  logic [12:0] ts_pid;
  logic        ts_pid_valid;
  logic        lk_valid, lk_hit, lk_scr_en;
  logic [7:0]  lk_cw_idx;
  logic        tbl_commit, tbl_err;
  logic [IDX_W:0] tbl_count;
  wr_state_t   dbg_state;

  always #5 clk = ~clk;

  csa_pid_table #(.TABLE_DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .pid_con_din    (pid_con_din),
    .pid_con_din_en (pid_con_din_en),
    .ts_pid         (ts_pid),
    .ts_pid_valid   (ts_pid_valid),
    .lk_valid       (lk_valid),
    .lk_hit         (lk_hit),
    .lk_scr_en      (lk_scr_en),
    .lk_cw_idx      (lk_cw_idx),
    .tbl_commit     (tbl_commit),
    .tbl_err        (tbl_err),
    .tbl_count      (tbl_count),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [9:0]  exp_q[$];      // {hit, scr_en, cw_idx}
  int          exp_cyc_q[$];  // issue cycle of each expected result

  // live reference table
  logic [12:0] m_pid[$];
  logic        m_scr[$];
  logic [7:0]  m_cw[$];
  int          m_n = 0;

  // frame under construction
  logic [7:0]  fb[$];
  logic [12:0] p_pid[$];
  logic        p_scr[$];
  logic [7:0]  p_cw[$];
  int          p_ndecl = 0;
  bit          ign_rand = 1'b0;

  // driver controls
  logic [7:0]  nxt_byte = 8'h00;
  logic        nxt_en   = 1'b0;
  logic        nxt_rst  = 1'b1;
  bit          rst_prev = 1'b1;
  int          lk_pct   = 0;
  int          force_pid = -1;
  logic [12:0] pool[$];
  int          ev_cyc = -1;
  bit          ev_ok  = 1'b0;

  bit          remap_on = 1'b0;
  logic [7:0]  remap_prev = 8'd5;
  int          remap_sw = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [9:0] model_lookup(input logic [12:0] pid);
    for (int i = 0; i < m_pid.size(); i++) begin
      if (m_pid[i] == pid) return {1'b1, m_scr[i], m_cw[i]};
    end
    return 10'h000;
  endfunction

  // One clock: check what the last edge produced, then drive the next inputs.
  task automatic step();
    logic [9:0]  e;
    int          c;
    logic [12:0] pid;
    @(negedge clk);
    cyc++;
    if (lk_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("lk_spurious", lk_valid, 0);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check_eq("lk_latency", cyc - c, 2);
        check_eq("lk_result", {lk_hit, lk_scr_en, lk_cw_idx}, e);
      end
      if (remap_on) begin
        if (lk_cw_idx != remap_prev) remap_sw++;
        remap_prev = lk_cw_idx;
      end
    end else if (exp_cyc_q.size() > 0 && cyc - exp_cyc_q[0] >= 2) begin
      check_eq("lk_missing", lk_valid, 1);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
    if (rst_prev) begin
      check_eq("rst_outputs", {lk_valid, lk_hit, lk_scr_en, lk_cw_idx, tbl_commit, tbl_err}, 0);
    end
    if (cyc == ev_cyc) begin
      check_eq("tbl_commit", tbl_commit, ev_ok);
      check_eq("tbl_err", tbl_err, !ev_ok);
      if (ev_ok) begin
        m_pid = p_pid;
        m_scr = p_scr;
        m_cw  = p_cw;
        m_n   = p_ndecl;
      end
      ev_cyc = -1;
    end else begin
      check_eq("commit_idle", tbl_commit, 0);
      check_eq("err_idle", tbl_err, 0);
    end
    check_eq("tbl_count", tbl_count, m_n);

    rst            = nxt_rst;
    rst_prev       = nxt_rst;
    pid_con_din    = nxt_byte;
    pid_con_din_en = nxt_en;
    ts_pid         = 13'($urandom);
    ts_pid_valid   = 1'b0;
    if (nxt_rst) begin
      exp_q.delete();
      exp_cyc_q.delete();
      m_pid.delete();
      m_scr.delete();
      m_cw.delete();
      m_n    = 0;
      ev_cyc = -1;
    end else if (force_pid >= 0 || (lk_pct > 0 && $urandom_range(0, 99) < lk_pct)) begin
      if (force_pid >= 0) pid = force_pid[12:0];
      else if (pool.size() > 0 && $urandom_range(0, 3) != 0)
        pid = pool[$urandom_range(0, pool.size() - 1)];
      else pid = 13'($urandom);
      ts_pid       = pid;
      ts_pid_valid = 1'b1;
      exp_q.push_back(model_lookup(pid));
      exp_cyc_q.push_back(cyc);
    end
  endtask

  task automatic frame_begin(input int n);
    fb.delete();
    p_pid.delete();
    p_scr.delete();
    p_cw.delete();
    p_ndecl = n;
    fb.push_back(8'(n));
  endtask

  task automatic frame_add(input logic [12:0] pid, input logic scr, input logic [7:0] cw);
    logic [7:0] flags, hi;
    flags = ign_rand ? {7'($urandom), scr} : {7'b0, scr};
    hi    = ign_rand ? {3'($urandom), pid[12:8]} : {3'b0, pid[12:8]};
    fb.push_back(flags);
    fb.push_back(hi);
    fb.push_back(pid[7:0]);
    fb.push_back(cw);
    p_pid.push_back(pid);
    p_scr.push_back(scr);
    p_cw.push_back(cw);
    pool.push_back(pid);
    if (pool.size() > 48) void'(pool.pop_front());
  endtask

  task automatic send_frame(input int gap);
    bit ok;
    int last;
    ok = (p_ndecl <= DEPTH) && (fb.size() == HDR_BYTES + ENTRY_BYTES * p_ndecl);
    for (int i = 0; i < fb.size(); i++) begin
      nxt_en   = 1'b1;
      nxt_byte = fb[i];
      step();
    end
    last     = cyc;
    nxt_en   = 1'b0;
    nxt_byte = 8'($urandom);
    ev_cyc   = last + 3;
    ev_ok    = ok;
    repeat ((gap < 4) ? 4 : gap) step();
  endtask

  task automatic look(input int pid);
    force_pid = pid;
    step();
    force_pid = -1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          base, n, extra;
    logic [12:0] list32[DEPTH];
    rst            = 1'b1;
    pid_con_din    = 8'h00;
    pid_con_din_en = 1'b0;
    ts_pid         = '0;
    ts_pid_valid   = 1'b0;

    repeat (3) step();
    nxt_rst = 1'b0;
    repeat (2) step();
    check_eq("state_after_rst", dbg_state, W_IDLE);

    // basic two-entry table
    lk_pct = 30;
    frame_begin(2);
    frame_add(13'h100, 1'b1, 8'd5);
    frame_add(13'h064, 1'b0, 8'd9);
    send_frame(6);
    look(13'h100);
    look(13'h064);
    look(13'h1FFF);
    repeat (3) step();

    // N=3 with only two entries: rejected, old table keeps answering
    frame_begin(3);
    frame_add(13'h100, 1'b0, 8'h77);
    frame_add(13'h064, 1'b1, 8'h66);
    send_frame(5);
    look(13'h100);
    look(13'h064);

    // oversized header
    ign_rand = 1'b1;
    frame_begin(33);
    for (int i = 0; i < 33; i++) frame_add(13'($urandom), 1'($urandom), 8'($urandom));
    send_frame(5);

    // full table, every PID must hit, back-to-back lookups
    base = $urandom_range(0, 4000);
    frame_begin(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      list32[i] = 13'(base + i * 37);
      frame_add(list32[i], 1'($urandom), 8'($urandom));
    end
    send_frame(5);
    for (int i = 0; i < DEPTH; i++) begin
      force_pid = int'(list32[i]);
      step();
    end
    force_pid = -1;
    repeat (3) step();

    // duplicate PID: lowest entry index wins
    frame_begin(5);
    frame_add(13'h200, 1'b1, 8'd1);
    for (int i = 1; i < 4; i++) frame_add(13'(13'h300 + i), 1'($urandom), 8'($urandom));
    frame_add(13'h200, 1'b0, 8'd7);
    send_frame(5);
    look(13'h200);
    look(13'h200);

    // empty table
    frame_begin(0);
    send_frame(5);
    repeat (10) step();

    // continuous lookups across a remap of 0x100 from cw 5 to cw 8
    frame_begin(1);
    frame_add(13'h100, 1'b1, 8'd5);
    send_frame(5);
    force_pid  = 13'h100;
    repeat (3) step();
    remap_prev = 8'd5;
    remap_sw   = 0;
    remap_on   = 1'b1;
    frame_begin(1);
    frame_add(13'h100, 1'b1, 8'd8);
    send_frame(8);
    remap_on  = 1'b0;
    force_pid = -1;
    check_eq("remap_switches", remap_sw, 1);

    // random frames, some malformed, small PID set to force duplicates
    lk_pct = 60;
    repeat (14) begin
      n = $urandom_range(0, 6);
      extra = $urandom_range(0, 5);
      frame_begin(n);
      if (extra == 0 && n > 0) n = n - 1;
      else if (extra == 1) n = n + 1;
      for (int i = 0; i < n; i++)
        frame_add(13'(13'h010 + $urandom_range(0, 5)), 1'($urandom), 8'($urandom));
      if (extra == 2 && fb.size() > 1) void'(fb.pop_back());
      send_frame($urandom_range(4, 8));
    end

    // reset in the middle of a frame: frame discarded, no error
    frame_begin(4);
    for (int i = 0; i < 4; i++) frame_add(13'(13'h400 + i), 1'b1, 8'(i + 1));
    for (int i = 0; i < fb.size(); i++) begin
      if (i == 7) nxt_rst = 1'b1;
      if (i == 9) nxt_rst = 1'b0;
      nxt_en   = 1'b1;
      nxt_byte = fb[i];
      step();
    end
    nxt_en = 1'b0;
    repeat (6) step();
    check_eq("state_after_midrst", dbg_state, W_IDLE);
    look(13'h100);
    look(13'h400);
    repeat (20) step();

    lk_pct = 0;
    repeat (4) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
